// File: rtl/demux_sequencer_pkg.sv
// Shared digitizer definitions for the demux sequencer: clog2 helper,
// sequencer state encoding and default burst/watchdog constants.
package demux_sequencer_pkg;

    // Ceiling log2; callers pass values >= 2 so the result is never zero.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    localparam int DEFAULT_BURST   = 8;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/demux_sequencer_demux.sv
// 1-to-N valid demux: routes a single valid bit to the output selected by sel.
module demux_sequencer_demux
    import demux_sequencer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  in,
    input  logic [clog2(N)-1:0]   sel,
    output logic [N-1:0]          out
);

    localparam int SELW = clog2(N);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            localparam logic [SELW-1:0] IDX = SELW'(gi);
            assign out[gi] = in && (sel == IDX);
        end
    endgenerate

endmodule

// File: rtl/demux_sequencer.sv
// Round-robin burst scheduler sharing one sample stream among N channels.
// Optional watchdog enabled by defining DEMUX_SEQ_WDOG_EN: a channel that
// stalls a pending word for TIMEOUT cycles loses its grant and sets err.
module demux_sequencer
    import demux_sequencer_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int BURST   = DEFAULT_BURST,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N-1:0]          ch_mask,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [W-1:0]          out_data,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [clog2(N)-1:0]   sel,
    output logic                  busy,
    output logic                  burst_done,
    output logic                  err
);

    localparam int SELW = clog2(N);
    localparam int CNTW = clog2(BURST + 1);

    state_e            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [CNTW-1:0]   burst_cnt_q, burst_cnt_d;

    logic              xfer;
    logic              last_word;
    logic [SELW-1:0]   sel_inc;

    // Explicit wrap so non-power-of-two channel counts never alias.
    assign sel_inc   = (sel_q == SELW'(N - 1)) ? '0 : sel_q + SELW'(1);
    assign xfer      = (state_q == ST_XFER) && in_valid && out_ready[sel_q];
    assign last_word = (burst_cnt_q == CNTW'(BURST - 1));

`ifdef DEMUX_SEQ_WDOG_EN
    localparam int WDW = clog2(TIMEOUT + 1);

    logic [WDW-1:0]    wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              stall;

    assign stall = (state_q == ST_XFER) && in_valid && !out_ready[sel_q];
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

    // State register: all sequencing state, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            burst_cnt_q <= '0;
`ifdef DEMUX_SEQ_WDOG_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            burst_cnt_q <= burst_cnt_d;
`ifdef DEMUX_SEQ_WDOG_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state logic: scan one candidate per cycle, hold grant for a full burst.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        burst_cnt_d = burst_cnt_q;
`ifdef DEMUX_SEQ_WDOG_EN
        wdog_d      = wdog_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && (|ch_mask)) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!enable || (ch_mask == '0)) begin
                    state_d = ST_IDLE;
                end else if (ch_mask[sel_q]) begin
                    state_d     = ST_XFER;
                    burst_cnt_d = '0;
`ifdef DEMUX_SEQ_WDOG_EN
                    wdog_d      = '0;
`endif
                end else begin
                    sel_d = sel_inc;
                end
            end
            ST_XFER: begin
                // enable and ch_mask are deliberately ignored: bursts are atomic.
                if (xfer) begin
`ifdef DEMUX_SEQ_WDOG_EN
                    wdog_d = '0;
`endif
                    if (last_word) begin
                        burst_cnt_d = '0;
                        sel_d       = sel_inc;
                        state_d     = ST_SCAN;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNTW'(1);
                    end
                end
`ifdef DEMUX_SEQ_WDOG_EN
                else if (stall) begin
                    if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        // Stuck channel: drop the partial burst and move on.
                        wdog_d      = '0;
                        err_d       = 1'b1;
                        burst_cnt_d = '0;
                        sel_d       = sel_inc;
                        state_d     = ST_SCAN;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: zero-latency handshake steering while a grant is held.
    always_comb begin
        busy       = (state_q == ST_XFER);
        in_ready   = busy && out_ready[sel_q];
        burst_done = xfer && last_word;
    end

    assign sel      = sel_q;
    assign out_data = in_data;

    demux_sequencer_demux #(
        .N   (N)
    ) u_demux (
        .in  (in_valid && busy),
        .sel (sel_q),
        .out (out_valid)
    );

endmodule

// File: tb/tb_demux_sequencer.sv
// Directed bench for demux_sequencer: per-cycle vector table for round robin,
// masked skip and back-pressure, plus hand sequences for async reset,
// enable drop on an 8-word burst and the watchdog (DEMUX_SEQ_WDOG_EN).
module tb_demux_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [15:0] in_data;
    logic        in_valid;
    logic [3:0]  out_ready;

    logic        in_ready, busy, burst_done, err;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [1:0]  sel;

    logic        o8_in_ready, o8_busy, o8_burst_done, o8_err;
    logic [15:0] o8_out_data;
    logic [3:0]  o8_out_valid;
    logic [1:0]  o8_sel;

    int n_total = 0;
    int n_pass  = 0;

    demux_sequencer #(.N(4), .W(16), .BURST(2), .TIMEOUT(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .ch_mask    (ch_mask),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy),
        .burst_done (burst_done),
        .err        (err)
    );

    demux_sequencer #(.N(4), .W(16), .BURST(8), .TIMEOUT(10)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .ch_mask    (ch_mask),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (o8_in_ready),
        .out_data   (o8_out_data),
        .out_valid  (o8_out_valid),
        .out_ready  (out_ready),
        .sel        (o8_sel),
        .busy       (o8_busy),
        .burst_done (o8_burst_done),
        .err        (o8_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic       vld;
        logic [3:0] rdy;
        logic [1:0] e_sel;
        logic [3:0] e_ov;
        logic       e_ir;
        logic       e_bd;
        logic       e_busy;
    } vec_t;

    vec_t vecs [0:43];
    int   nv = 0;

    task automatic add(input logic en, input logic [3:0] mask, input logic vld,
                       input logic [3:0] rdy, input logic [1:0] e_sel,
                       input logic [3:0] e_ov, input logic e_ir, input logic e_bd,
                       input logic e_busy);
        vecs[nv].en     = en;
        vecs[nv].mask   = mask;
        vecs[nv].vld    = vld;
        vecs[nv].rdy    = rdy;
        vecs[nv].e_sel  = e_sel;
        vecs[nv].e_ov   = e_ov;
        vecs[nv].e_ir   = e_ir;
        vecs[nv].e_bd   = e_bd;
        vecs[nv].e_busy = e_busy;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        ch_mask   = 4'b0000;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // Round robin, BURST=2, all channels, one SCAN bubble between bursts.
        add(1, 4'hF, 1, 4'hF, 0, 4'b0000, 0, 0, 0); // 0  IDLE
        add(1, 4'hF, 1, 4'hF, 0, 4'b0000, 0, 0, 0); // 1  SCAN ch0
        add(1, 4'hF, 1, 4'hF, 0, 4'b0001, 1, 0, 1); // 2  word0
        add(1, 4'hF, 1, 4'hF, 0, 4'b0001, 1, 1, 1); // 3  word1
        add(1, 4'hF, 1, 4'hF, 1, 4'b0000, 0, 0, 0); // 4  SCAN ch1
        add(1, 4'hF, 1, 4'hF, 1, 4'b0010, 1, 0, 1); // 5  word2
        add(1, 4'hF, 1, 4'hF, 1, 4'b0010, 1, 1, 1); // 6  word3
        add(1, 4'hF, 1, 4'hF, 2, 4'b0000, 0, 0, 0); // 7  SCAN ch2
        add(1, 4'hF, 1, 4'hF, 2, 4'b0100, 1, 0, 1); // 8  word4
        add(1, 4'hF, 1, 4'hF, 2, 4'b0100, 1, 1, 1); // 9  word5
        add(1, 4'hF, 1, 4'hF, 3, 4'b0000, 0, 0, 0); // 10 SCAN ch3
        add(1, 4'hF, 1, 4'hF, 3, 4'b1000, 1, 0, 1); // 11 word6
        add(1, 4'hF, 1, 4'hF, 3, 4'b1000, 1, 1, 1); // 12 word7
        // Masked skip, mask 1010: grants 1,3,1,3.
        add(1, 4'hA, 1, 4'hF, 0, 4'b0000, 0, 0, 0); // 13 skip ch0
        add(1, 4'hA, 1, 4'hF, 1, 4'b0000, 0, 0, 0); // 14 SCAN ch1
        add(1, 4'hA, 1, 4'hF, 1, 4'b0010, 1, 0, 1); // 15
        add(1, 4'hA, 1, 4'hF, 1, 4'b0010, 1, 1, 1); // 16
        add(1, 4'hA, 1, 4'hF, 2, 4'b0000, 0, 0, 0); // 17 skip ch2
        add(1, 4'hA, 1, 4'hF, 3, 4'b0000, 0, 0, 0); // 18 SCAN ch3
        add(1, 4'hA, 1, 4'hF, 3, 4'b1000, 1, 0, 1); // 19
        add(1, 4'hA, 1, 4'hF, 3, 4'b1000, 1, 1, 1); // 20
        add(1, 4'hA, 1, 4'hF, 0, 4'b0000, 0, 0, 0); // 21 skip ch0
        add(1, 4'hA, 1, 4'hF, 1, 4'b0000, 0, 0, 0); // 22
        add(1, 4'hA, 1, 4'hF, 1, 4'b0010, 1, 0, 1); // 23
        add(1, 4'hA, 1, 4'hF, 1, 4'b0010, 1, 1, 1); // 24
        add(1, 4'hA, 1, 4'hF, 2, 4'b0000, 0, 0, 0); // 25 skip ch2
        add(1, 4'hA, 1, 4'hF, 3, 4'b0000, 0, 0, 0); // 26
        add(1, 4'hA, 1, 4'hF, 3, 4'b1000, 1, 0, 1); // 27
        add(1, 4'hA, 1, 4'hF, 3, 4'b1000, 1, 1, 1); // 28
        // Back-pressure: ch1 not ready for 5 cycles mid-burst.
        add(1, 4'hA, 1, 4'hF, 0, 4'b0000, 0, 0, 0); // 29 skip ch0
        add(1, 4'hA, 1, 4'hF, 1, 4'b0000, 0, 0, 0); // 30
        add(1, 4'hA, 1, 4'hF, 1, 4'b0010, 1, 0, 1); // 31 first word
        add(1, 4'hA, 1, 4'hD, 1, 4'b0010, 0, 0, 1); // 32 stall
        add(1, 4'hA, 1, 4'hD, 1, 4'b0010, 0, 0, 1); // 33
        add(1, 4'hA, 1, 4'hD, 1, 4'b0010, 0, 0, 1); // 34
        add(1, 4'hA, 1, 4'hD, 1, 4'b0010, 0, 0, 1); // 35
        add(1, 4'hA, 1, 4'hD, 1, 4'b0010, 0, 0, 1); // 36
        add(1, 4'hA, 1, 4'hF, 1, 4'b0010, 1, 1, 1); // 37 second word
        add(0, 4'hA, 1, 4'hF, 2, 4'b0000, 0, 0, 0); // 38 SCAN sees enable=0
        add(0, 4'hA, 1, 4'hF, 2, 4'b0000, 0, 0, 0); // 39 IDLE
        add(1, 4'hA, 1, 4'hF, 2, 4'b0000, 0, 0, 0); // 40 IDLE -> SCAN
        add(1, 4'hA, 1, 4'hF, 2, 4'b0000, 0, 0, 0); // 41 skip ch2
        add(1, 4'hA, 1, 4'hF, 3, 4'b0000, 0, 0, 0); // 42
        add(1, 4'hA, 1, 4'hF, 3, 4'b1000, 1, 0, 1); // 43 word into ch3

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {28'd0, sel, busy, burst_done}, 32'd0);
        chk("reset_handshake", {26'd0, out_valid, in_ready, err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            enable    = vecs[i].en;
            ch_mask   = vecs[i].mask;
            in_valid  = vecs[i].vld;
            out_ready = vecs[i].rdy;
            in_data   = 16'hA000 + 16'(i);
            #1;
            chk($sformatf("vec%0d", i),
                {6'd0, sel, out_valid, in_ready, burst_done, busy, err, out_data},
                {6'd0, vecs[i].e_sel, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_bd,
                 vecs[i].e_busy, 1'b0, 16'hA000 + 16'(i)});
            $display("vec %0d sel=%0d ov=%b ir=%b bd=%b busy=%b", i, sel, out_valid,
                     in_ready, burst_done, busy);
        end

        // Asynchronous reset mid-XFER, applied between clock edges.
        @(posedge clk);
        #2;
        chk("pre_reset_xfer", {28'd0, sel, busy, in_ready}, {28'd0, 2'd3, 1'b1, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("async_reset", {24'd0, sel, out_valid, in_ready, busy}, 32'd0);
        $display("async reset sel=%0d ov=%b ir=%b", sel, out_valid, in_ready);

        // Enable drop after word 1 of an 8-word burst (BURST=8 instance).
        @(negedge clk);
        rst_n     = 1'b1;
        enable    = 1'b1;
        ch_mask   = 4'hF;
        in_valid  = 1'b1;
        out_ready = 4'hF;
        #1;
        chk("en_idle", {30'd0, o8_busy, o8_in_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("en_scan", {28'd0, o8_sel, o8_busy, o8_in_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) enable = 1'b0;
            #1;
            chk($sformatf("en_word%0d", i),
                {25'd0, o8_sel, o8_out_valid, o8_in_ready, o8_burst_done},
                {25'd0, 2'd0, 4'b0001, 1'b1, (i == 7)});
            $display("en-drop word %0d ov=%b bd=%b", i, o8_out_valid, o8_burst_done);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("en_after%0d", c), {25'd0, o8_sel, o8_out_valid, o8_busy},
                {25'd0, 2'd1, 4'b0000, 1'b0});
        end

        // Watchdog: only channel 2 enabled, and it is never ready.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        enable    = 1'b1;
        ch_mask   = 4'b0100;
        in_valid  = 1'b1;
        out_ready = 4'b1011;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            #1;
            if (c == 4) begin
                chk("wd_stall_start", {24'd0, sel, out_valid, in_ready, busy},
                    {24'd0, 2'd2, 4'b0100, 1'b0, 1'b1});
            end
            if (c == 13) begin
                chk("wd_stall_10", {28'd0, sel, busy, err}, {28'd0, 2'd2, 1'b1, 1'b0});
            end
        end
`ifdef DEMUX_SEQ_WDOG_EN
        chk("wd_abort", {28'd0, sel, busy, err}, {28'd0, 2'd3, 1'b0, 1'b1});
        chk("wd_no_done", {31'd0, burst_done}, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("wd_sticky", {31'd0, err}, 32'd1);
`else
        chk("wd_off_stall", {28'd0, sel, busy, err}, {28'd0, 2'd2, 1'b1, 1'b0});
        repeat (5) @(negedge clk);
        #1;
        chk("wd_off_still", {28'd0, sel, busy, err}, {28'd0, 2'd2, 1'b1, 1'b0});
`endif
        $display("watchdog phase sel=%0d busy=%b err=%b", sel, busy, err);
        rst_n = 1'b0;
        #1;
        chk("wd_err_cleared", {30'd0, err, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demux_sequencer.md
Name: demux_sequencer

Overview:
- Round-robin scheduler that shares one incoming digitizer sample stream between N downstream channel consumers.
- Drives the select of the existing 1-to-N demux for the valid fan-out.
- Grants a channel an atomic burst of BURST words, then advances to the next enabled channel.
- Sits between the ADC capture FIFO and the per-channel packet buffers.

Parameters:
- N, 4, number of destination channels; N >= 2, need not be a power of two.
- W, 16, data word width.
- BURST, 8, words per grant; BURST >= 1.
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run enable.
- ch_mask  in  N  per-channel enable; bit i set means channel i participates.
- in_data  in  W  upstream data word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  upstream accept.
- out_data  out  W  broadcast to all channels; equals in_data.
- out_valid  out  N  one-hot valid to the selected channel, produced by the demux.
- out_ready  in  N  per-channel ready.
- sel  out  clog2(N)  current channel select.
- busy  out  1  high when the state is XFER.
- burst_done  out  1  one-cycle pulse on the last word of a burst.
- err  out  1  sticky watchdog error; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, sel = 0, burst_cnt = 0, busy = 0, burst_done = 0, err = 0.
  - in_ready = 0 and out_valid = 0 while not in XFER.
- States: IDLE, SCAN, XFER. Transitions:
  - IDLE: go to SCAN when enable && |ch_mask. Otherwise stay.
  - SCAN: test one candidate per cycle.
    - If enable = 0 or ch_mask = 0, go to IDLE.
    - If ch_mask[sel] = 1, go to XFER with burst_cnt = 0.
    - Otherwise sel = (sel == N-1) ? 0 : sel + 1.
    - A full scan takes at most N cycles.
  - XFER: combinational, zero-latency pass-through.
    - in_ready = out_ready[sel].
    - out_valid = demux(in_valid, sel).
    - A transfer occurs when in_valid && out_ready[sel].
    - Each transfer increments burst_cnt.
    - On the transfer with burst_cnt == BURST-1:
      - burst_done = 1 in the same cycle (combinational).
      - Next cycle: burst_cnt = 0, sel advances with wrap at N-1 -> 0, state = SCAN.
  - XFER stalls indefinitely without the optional feature.
- Burst atomicity:
  - Deasserting enable mid-burst does not abort; the burst completes, then SCAN sees enable = 0 and goes to IDLE.
  - Clearing ch_mask[sel] mid-burst also does not abort; the mask is sampled only in SCAN.
- Widths and arithmetic:
  - burst_cnt is clog2(BURST+1) bits.
  - sel wraps explicitly, never by overflow, so non-power-of-two N is legal.
- Data path:
  - out_data = in_data at all times; no data register.
  - Only valid and ready are steered.
- Simultaneous events:
  - A transfer on the last burst word while enable falls still counts and pulses burst_done.
- Reset mid-burst drops the partial burst; the upstream must tolerate a re-sent word.

Optional Feature:
- Macro DEMUX_SEQ_WDOG_EN.
- Defined:
  - A wdog counter of clog2(TIMEOUT+1) bits runs in XFER.
  - It counts while in_valid && !out_ready[sel] and clears on every transfer and on entry to XFER.
  - When it reaches TIMEOUT: abort the burst, set err (sticky until rst_n), advance sel, go to SCAN. burst_done does not pulse.
- Undefined: no counter, err tied 0, XFER stalls indefinitely.

Decomposition:
- Shared digitizer package holds:
  - the clog2 function;
  - a state enum/localparams (ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_XFER = 2'd2);
  - default BURST and TIMEOUT constants.
- Sub-module: reuse the existing demux (parameter N) for out_valid, driven by in = in_valid && busy and sel = sel.
- All sequencing stays in demux_sequencer.

Test Plan:
- Basic round robin:
  - N=4, BURST=2, mask=4'b1111, in_valid constant, all ready.
  - Words 0..7 go to channels 0,0,1,1,2,2,3,3.
  - burst_done pulses on words 1,3,5,7.
  - One SCAN bubble cycle between bursts.
- Masked skip:
  - mask=4'b1010.
  - Grants alternate 1,3,1,3.
  - SCAN spends 1 extra cycle skipping channel 2 and channel 0.
- Back-pressure:
  - out_ready[1] = 0 for 5 cycles mid-burst.
  - in_ready = 0 and no out_valid on other channels during the stall.
  - Burst resumes; word count is still exactly BURST.
- Enable drop:
  - Deassert enable after word 1 of an 8-word burst.
  - Remaining 6 words delivered to the same channel, then IDLE, sel = next channel.
- Watchdog (DEMUX_SEQ_WDOG_EN, TIMEOUT=10):
  - Channel 2 is never ready.
  - After 10 stalled cycles: err = 1, sel = 3, state SCAN.
  - err stays 1 until rst_n pulse.
- Async reset:
  - Assert rst_n = 0 mid-XFER, off a clock edge.
  - Outputs are immediately at reset values: sel = 0, in_ready = 0, out_valid = 0.
